// File: rtl/axi_rd_if.sv
// -----------------------------------------------------------------------------
// axi_rd_if -- AXI4 read address (AR) and read data (R) channel bundle.
//
// Modports:
//   master : the initiator side (core PC/LSU, interconnect); drives AR and rready
//   slave  : the memory side (axi_rd_responder); drives arready and R
//
// Signals:
//   arvalid/arready       AR handshake
//   arid, araddr, arlen   request ID, start byte address, beats-1
//   arsize, arburst       log2(bytes/beat); 00 FIXED, 01 INCR, 10 WRAP
//   rvalid/rready         R handshake
//   rid, rdata            echoed ID, beat data
//   rresp, rlast          00 OKAY, 10 SLVERR, 11 DECERR; final beat marker
// -----------------------------------------------------------------------------
interface axi_rd_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) ();

  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axi_rd_responder.sv
// -----------------------------------------------------------------------------
// axi_rd_responder -- AXI4 read-channel slave in front of a synchronous
// SRAM-style memory port. One request is accepted at a time; its FIXED or INCR
// burst is walked beat by beat, and each SRAM word comes back as an R beat
// with rid/rresp/rlast.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   bus        axi_rd_if.slave (AR + R channels)
//   mem_en     SRAM read strobe, one cycle per beat
//   mem_addr   SRAM word index of the current beat
//   mem_rdata  SRAM data, valid the cycle after mem_en, held until the next mem_en
//
// Every beat costs READ -> (WAIT x WAIT) -> CAP -> RESP. Requests that fail
// the window/size/burst checks at AR time go straight to RESP and return
// len+1 zero-data beats carrying the error code, never touching the SRAM.
// -----------------------------------------------------------------------------
module axi_rd_responder #(
  parameter int                ADDR_W = 64,
  parameter int                DATA_W = 64,
  parameter int                LEN_W  = 8,
  parameter int                ID_W   = 4,
  parameter int                MEM_AW = 16,
  parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
  parameter int                WAIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  axi_rd_if.slave           bus,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Byte-offset bits inside one data word, and byte-address bits of the window.
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int WIN_AW = MEM_AW + OFF_W;

  // Window bounds in ADDR_W+1 bits so the end-of-burst sum cannot wrap.
  localparam logic [ADDR_W:0]   ONE_X  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   WIN_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0]   WIN_HI = WIN_LO + (ONE_X << WIN_AW);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  ONE_L  = LEN_W'(1);
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT > 0 ? WAIT - 1 : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAP,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic              arready_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [1:0]        resp_q;
  logic [3:0]        wait_q;
  logic [DATA_W-1:0] rdata_q;

  logic              ar_hs;
  logic              last_beat;
  logic [1:0]        ar_resp;
  logic [ADDR_W:0]   ar_start;
  logic [ADDR_W:0]   ar_bytes;
  logic [ADDR_W:0]   ar_end;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] addr_nx;

  assign ar_hs     = bus.arvalid && arready_q;
  assign last_beat = (beat_q == len_q);

  // Error code for the incoming request. DECERR (outside the window, or an
  // INCR burst whose last byte leaves it) outranks SLVERR (WRAP/reserved burst,
  // or a beat wider than the data bus).
  always_comb begin
    ar_start = {1'b0, bus.araddr};
    ar_bytes = ((ADDR_W + 1)'(bus.arlen) + ONE_X) << bus.arsize;
    ar_end   = ar_start + ar_bytes - ONE_X;
    if ((ar_start < WIN_LO) || (ar_start >= WIN_HI) ||
        ((bus.arburst == BURST_INCR) && (ar_end >= WIN_HI)))
      ar_resp = RESP_DECERR;
    else if (bus.arburst[1] || (int'(bus.arsize) > OFF_W))
      ar_resp = RESP_SLVERR;
    else
      ar_resp = RESP_OKAY;
  end

  // Next beat address: INCR aligns down to the beat size then steps one beat,
  // so an unaligned start realigns on the second beat; FIXED stays put.
  assign step    = ONE_A << size_q;
  assign addr_nx = (burst_q == BURST_INCR) ? ((addr_q & ~(step - ONE_A)) + step) : addr_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx   = state;
    mem_en     = 1'b0;
    mem_addr   = '0;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ar_hs) state_nx = (ar_resp == RESP_OKAY) ? S_READ : S_RESP;
      end
      S_READ: begin
        mem_en   = 1'b1;
        mem_addr = MEM_AW'((addr_q - BASE) >> OFF_W);
        state_nx = (WAIT > 0) ? S_WAIT : S_CAP;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_nx = S_CAP;
      end
      S_CAP: begin
        state_nx = S_RESP;
      end
      S_RESP: begin
        bus.rvalid = 1'b1;
        bus.rlast  = last_beat;
        if (bus.rready) begin
          if (last_beat)                 state_nx = S_IDLE;
          else if (resp_q == RESP_OKAY)  state_nx = S_READ;
          else                           state_nx = S_RESP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: rdata_q is an ordinary register (not an array) and is cleared so
      // the R bus reads zero after reset; the SRAM behind mem_* is never reset.
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      resp_q    <= RESP_OKAY;
      wait_q    <= '0;
      rdata_q   <= '0;
    end else begin
      // arready is registered: high exactly in IDLE, and only from the cycle
      // after reset is released.
      arready_q <= (state_nx == S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (ar_hs) begin
            id_q    <= bus.arid;
            addr_q  <= bus.araddr;
            len_q   <= bus.arlen;
            size_q  <= bus.arsize;
            burst_q <= bus.arburst;
            resp_q  <= ar_resp;
            beat_q  <= '0;
            rdata_q <= '0;   // error bursts return zero data on every beat
          end
        end
        S_READ: wait_q  <= '0;
        S_WAIT: wait_q  <= wait_q + 4'd1;
        S_CAP:  rdata_q <= mem_rdata;
        S_RESP: begin
          if (bus.rready && !last_beat) begin
            addr_q <= addr_nx;
            beat_q <= beat_q + ONE_L;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rid     = id_q;
  assign bus.rresp   = resp_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_responder -- bench for axi_rd_responder.
// dut   : WAIT=0, checked every cycle against a transaction-level model
//         (expected beat list built at AR accept, cycle ages for timing).
// dut_w : WAIT=3, used for the wait-state latency case only.
// Inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_axi_rd_responder;

  localparam int          ADDR_W = 64;
  localparam int          DATA_W = 64;
  localparam int          LEN_W  = 8;
  localparam int          ID_W   = 4;
  localparam int          MEM_AW = 16;
  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [64:0] WIN_END = 65'h8000_0000 + 65'h8_0000;  // 2^16 words * 8 bytes

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();
  axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus_w ();

  logic              mem_en, mem_en_w;
  logic [MEM_AW-1:0] mem_addr, mem_addr_w;
  logic [DATA_W-1:0] mem_rdata, mem_rdata_w;

  axi_rd_responder #(.WAIT(0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  axi_rd_responder #(.WAIT(3)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w),
    .mem_en(mem_en_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w)
  );

  // Memory contents are a pure function of the word index.
  function automatic logic [63:0] mem_word(input logic [15:0] w);
    if (w == 16'd1) return 64'h1122_3344_5566_7788;
    return {w, ~w, w ^ 16'h5a5a, 16'hc0de};
  endfunction

  always @(posedge clk) if (mem_en)   mem_rdata   <= mem_word(mem_addr);
  always @(posedge clk) if (mem_en_w) mem_rdata_w <= mem_word(mem_addr_w);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [15:0] word;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       m_q[$];
  logic        m_busy = 1'b0;
  logic        m_arready = 1'b0;
  logic        m_inrst = 1'b1;
  logic [3:0]  m_id = '0;
  logic [1:0]  m_resp = '0;
  int          m_age = 0;

  task automatic m_accept();
    logic [64:0] s, e;
    logic [63:0] a, bsz;
    logic        dec, slv;
    beat_t       b;
    bsz = 64'd1 << bus.arsize;
    s   = {1'b0, bus.araddr};
    e   = s + (65'(bus.arlen) + 65'd1) * {1'b0, bsz} - 65'd1;
    dec = (s < {1'b0, BASE}) || (s >= WIN_END) || (bus.arburst == 2'b01 && e >= WIN_END);
    slv = (bus.arburst > 2'b01) || (bus.arsize > 3'd3);
    m_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    m_id   = bus.arid;
    a      = bus.araddr;
    for (int i = 0; i <= int'(bus.arlen); i++) begin
      b.word = 16'((a - BASE) / 64'd8);
      b.data = (m_resp == 2'b00) ? mem_word(b.word) : 64'd0;
      b.last = (i == int'(bus.arlen));
      m_q.push_back(b);
      if (bus.arburst == 2'b01) a = (a / bsz) * bsz + bsz;
    end
  endtask

  initial begin : model
    logic exp_rvalid, exp_mem;
    forever begin
      @(negedge clk);
      exp_rvalid = m_busy && (m_q.size() > 0) && (m_age >= ((m_resp != 2'b00) ? 0 : 2));
      exp_mem    = m_busy && (m_q.size() > 0) && (m_resp == 2'b00) && (m_age == 0);
      if (m_inrst) begin
        check("rst_arready", bus.arready, 0);
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_rlast",   bus.rlast,   0);
        check("rst_rresp",   bus.rresp,   0);
        check("rst_rid",     bus.rid,     0);
        check("rst_rdata",   bus.rdata,   0);
        check("rst_mem_en",  mem_en,      0);
        check("rst_mem_addr", mem_addr,   0);
      end else begin
        check("arready", bus.arready, m_arready);
        check("rvalid",  bus.rvalid,  exp_rvalid);
        check("mem_en",  mem_en,      exp_mem);
        if (exp_mem) check("mem_addr", mem_addr, m_q[0].word);
        if (exp_rvalid) begin
          check("rid",   bus.rid,   m_id);
          check("rdata", bus.rdata, m_q[0].data);
          check("rresp", bus.rresp, m_resp);
          check("rlast", bus.rlast, m_q[0].last);
        end
      end
      // Advance to the state after the coming posedge.
      if (reset) begin
        m_inrst = 1'b1; m_busy = 1'b0; m_arready = 1'b0; m_q.delete();
      end else begin
        m_inrst = 1'b0;
        if (exp_rvalid && bus.rready) begin
          if (m_q[0].last) m_busy = 1'b0;
          m_age = 0;
          void'(m_q.pop_front());
        end else if (!m_busy && m_arready && bus.arvalid) begin
          m_accept();
          m_busy = 1'b1;
          m_age  = 0;
        end else begin
          m_age++;
        end
        m_arready = !m_busy;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic        rr_random = 1'b0;
  logic [15:0] seen_addr[$];

  task automatic tick();
    @(posedge clk); #1;
    if (rr_random) bus.rready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic ar_drive(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
  endtask

  task automatic ar_wait();
    logic got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      neg();
      got = bus.arready;
      tick();
    end
    bus.arvalid = 1'b0;
    check("ar_accepted_in_time", got, 1);
  endtask

  task automatic wait_idle(output int beats, output logic [1:0] resp, output logic [63:0] dor);
    logic done = 1'b0;
    beats = 0; resp = 2'b00; dor = '0;
    seen_addr.delete();
    for (int i = 0; i < 3000 && !done; i++) begin
      neg();
      if (mem_en) seen_addr.push_back(mem_addr);
      if (bus.rvalid && bus.rready) begin
        beats++; resp = bus.rresp; dor |= bus.rdata;
      end
      done = bus.arready;
      tick();
    end
    check("burst_done_in_time", done, 1);
  endtask

  task automatic wait_rvalid();
    logic got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      neg();
      got = bus.rvalid;
      if (!got) tick();
    end
    check("rvalid_in_time", got, 1);
  endtask

  initial begin : main
    int          beats;
    logic [1:0]  resp;
    logic [63:0] dor;
    int          low_cnt;
    logic        got;

    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
    bus.arsize = 0; bus.arburst = 0; bus.rready = 0;
    bus_w.arvalid = 0; bus_w.arid = 0; bus_w.araddr = 0; bus_w.arlen = 0;
    bus_w.arsize = 0; bus_w.arburst = 0; bus_w.rready = 1;

    repeat (4) tick();
    reset = 1'b0;
    tick();
    neg(); check("arready_after_reset", bus.arready, 1);
    tick();

    // Single beat, word 1.
    bus.rready = 1'b1;
    ar_drive(4'd1, 64'h8000_0008, 8'd0, 3'd3, 2'b01);
    ar_wait();
    neg(); check("single_mem_en", mem_en, 1); check("single_mem_addr", mem_addr, 1);
    neg(); check("single_rvalid_T2", bus.rvalid, 0);
    neg(); check("single_rvalid_T3", bus.rvalid, 1);
    check("single_rdata", bus.rdata, 64'h1122_3344_5566_7788);
    check("single_rresp", bus.rresp, 0);
    check("single_rlast", bus.rlast, 1);
    neg(); check("single_arready_after", bus.arready, 1);
    tick();

    // INCR x4 from base, rready high.
    ar_drive(4'd5, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    ar_wait();
    wait_idle(beats, resp, dor);
    check("incr_beats", beats, 4);
    check("incr_mem_count", seen_addr.size(), 4);
    for (int i = 0; i < seen_addr.size(); i++) check("incr_mem_addr", seen_addr[i], i);

    // Same burst with beat 2 back-pressured.
    ar_drive(4'd5, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    ar_wait();
    wait_rvalid();
    tick();                       // beat 1 handshake
    bus.rready = 1'b0;
    wait_rvalid();                // beat 2 presented
    for (int i = 0; i < 5; i++) begin
      tick(); neg();
      check("bp_rvalid", bus.rvalid, 1);
      check("bp_rdata",  bus.rdata, 64'h1122_3344_5566_7788);
      check("bp_rlast",  bus.rlast, 0);
      check("bp_rid",    bus.rid, 5);
      check("bp_mem_en", mem_en, 0);
    end
    tick();
    bus.rready = 1'b1;
    wait_idle(beats, resp, dor);
    check("bp_remaining_beats", beats, 3);
    check("bp_remaining_mem", seen_addr.size(), 2);

    // FIXED x3 at word 2.
    ar_drive(4'd2, 64'h8000_0010, 8'd2, 3'd3, 2'b00);
    ar_wait();
    wait_idle(beats, resp, dor);
    check("fixed_beats", beats, 3);
    check("fixed_mem_count", seen_addr.size(), 3);
    for (int i = 0; i < seen_addr.size(); i++) check("fixed_mem_addr", seen_addr[i], 2);

    // WAIT=3 instance: rvalid at T+6.
    bus_w.arid = 4'd7; bus_w.araddr = 64'h8000_0010; bus_w.arlen = 8'd0;
    bus_w.arsize = 3'd3; bus_w.arburst = 2'b01; bus_w.arvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      neg(); got = bus_w.arready; tick();
    end
    bus_w.arvalid = 1'b0;
    check("w3_accepted", got, 1);
    neg(); check("w3_mem_en", mem_en_w, 1); check("w3_mem_addr", mem_addr_w, 2);
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin neg(); if (!bus_w.rvalid) low_cnt++; end
    check("w3_rvalid_low_T2_T5", low_cnt, 4);
    neg(); check("w3_rvalid_T6", bus_w.rvalid, 1);
    check("w3_rdata", bus_w.rdata, mem_word(16'd2));
    check("w3_rid", bus_w.rid, 7);
    neg(); check("w3_arready_after", bus_w.arready, 1);
    tick();

    // Error bursts.
    ar_drive(4'd3, 64'h0, 8'd1, 3'd3, 2'b01);
    ar_wait(); wait_idle(beats, resp, dor);
    check("decerr_beats", beats, 2); check("decerr_resp", resp, 2'b11);
    check("decerr_data", dor, 0); check("decerr_no_mem", seen_addr.size(), 0);

    ar_drive(4'd3, 64'h8000_0000, 8'd1, 3'd3, 2'b10);
    ar_wait(); wait_idle(beats, resp, dor);
    check("wrap_resp", resp, 2'b10); check("wrap_no_mem", seen_addr.size(), 0);

    ar_drive(4'd3, 64'h8000_0000, 8'd0, 3'd4, 2'b01);
    ar_wait(); wait_idle(beats, resp, dor);
    check("size_resp", resp, 2'b10); check("size_no_mem", seen_addr.size(), 0);

    ar_drive(4'd3, 64'h8007_FFF8, 8'd1, 3'd3, 2'b01);
    ar_wait(); wait_idle(beats, resp, dor);
    check("end_out_resp", resp, 2'b11); check("end_out_beats", beats, 2);
    check("end_out_no_mem", seen_addr.size(), 0);

    ar_drive(4'd3, 64'h8007_FFF8, 8'd0, 3'd3, 2'b01);
    ar_wait(); wait_idle(beats, resp, dor);
    check("last_word_resp", resp, 2'b00);
    check("last_word_mem_count", seen_addr.size(), 1);
    if (seen_addr.size() > 0) check("last_word_mem_addr", seen_addr[0], 16'hFFFF);

    // Random traffic; next request is held on arvalid while the burst runs.
    rr_random = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 64'($urandom);
      else if (sel == 1) addr = BASE + 64'h8_0000 - 64'($urandom_range(1, 64));
      else               addr = BASE + 64'($urandom_range(0, 32'h7_FFFF));
      sel   = $urandom_range(0, 9);
      size  = (sel == 9) ? 3'd4 : 3'(sel % 4);
      sel   = $urandom_range(0, 9);
      burst = (sel < 6) ? 2'b01 : (sel < 8) ? 2'b00 : 2'(sel - 6);
      ar_drive(4'($urandom), addr, 8'($urandom_range(0, 7)), size, burst);
      ar_wait();
    end
    rr_random = 1'b0;
    bus.rready = 1'b1;
    wait_idle(beats, resp, dor);

    // Reset during beat 2 of a 4-beat burst; next AR held across reset.
    ar_drive(4'd6, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    ar_wait();
    wait_rvalid();
    tick();
    bus.rready = 1'b0;
    wait_rvalid();
    tick();
    reset = 1'b1;
    ar_drive(4'd9, 64'h8000_0020, 8'd0, 3'd3, 2'b01);
    tick();
    neg(); check("rst_mid_rvalid", bus.rvalid, 0);
    tick(); tick();
    reset = 1'b0;
    bus.rready = 1'b1;
    ar_wait();
    wait_idle(beats, resp, dor);
    check("post_rst_beats", beats, 1);
    check("post_rst_mem_count", seen_addr.size(), 1);
    if (seen_addr.size() > 0) check("post_rst_mem_addr", seen_addr[0], 4);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel responder (slave): the memory-side end of the instruction/data fetch AR/R interface driven by the core's PC/LSU initiators.
- Accepts one AR request at a time, walks a FIXED or INCR burst, reads a synchronous SRAM-style backing port, and returns R beats with rlast/rresp.
- Sits between the AXI interconnect and the simulation/on-chip memory.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (power of 2, >=8)
- LEN_W, 8, arlen width
- ID_W, 4, arid/rid width
- MEM_AW, 16, SRAM word-address width; valid range is byte addresses [BASE, BASE + 2^MEM_AW * DATA_W/8)
- BASE, 64'h8000_0000, base byte address of the memory window
- WAIT, 0, extra SRAM wait cycles per beat (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- arvalid  in  1  AR request valid
- arready  out  1  AR accept
- arid  in  ID_W  request ID
- araddr  in  ADDR_W  start byte address
- arlen  in  LEN_W  beats-1
- arsize  in  3  log2(bytes/beat)
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- rvalid  out  1  read data valid
- rready  in  1  read data accept
- rid  out  ID_W  echoed arid
- rdata  out  DATA_W  beat data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  final beat
- mem_en  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word index
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_en, stable until the next mem_en

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_en=0, mem_addr=0. State goes to IDLE. arready rises the cycle after reset deasserts.
- States:
  - IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst, and the error code; beat counter=0. Next state is READ if the error code is OKAY, else RESP.
  - READ: one cycle, mem_en=1, mem_addr=(addr-BASE)>>log2(DATA_W/8). Next state is WAIT if WAIT>0, else CAP.
  - WAIT: count WAIT cycles, then go to CAP.
  - CAP: one cycle; rdata<=mem_rdata; go to RESP.
  - RESP: rvalid=1. rid, rdata, rresp and rlast stay stable until rready. On handshake:
    - If rlast, go to IDLE.
    - Otherwise advance addr, increment the beat counter, and go to READ (or stay in RESP for error bursts).
- Latency, no backpressure: AR handshake at edge T; mem_en during cycle T+1; rvalid first high in cycle T+3+WAIT. Each subsequent beat takes 3+WAIT cycles after the previous R handshake.
- rlast=1 when beat counter==latched len.
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr = (addr & ~(2^size-1)) + 2^size. The first unaligned beat realigns.
  - Arithmetic is ADDR_W-bit modulo. 4 KB crossing is not checked.
- Error code, decided at AR accept and applied to every beat:
  - DECERR if araddr is outside the window, or if (INCR) the final byte address start+(len+1)*2^size-1 is outside it.
  - Otherwise SLVERR if arburst is WAWRAP/reserved or 2^arsize > DATA_W/8.
  - DECERR takes priority over SLVERR.
  - Error bursts still return exactly len+1 beats with rdata=0, never assert mem_en, and skip READ/WAIT/CAP.
- Single outstanding transaction: arready=0 outside IDLE. rdata is the full SRAM word; lane selection is the initiator's job.
- arvalid held across reset or during a burst is accepted only on the next IDLE cycle.
- Reset mid-burst: the burst is abandoned and no further beats are produced. rvalid drops the cycle after reset is sampled.
- rready held high while rvalid=0 has no effect. rvalid never drops without a handshake, except on reset.

Test Plan:
- Single beat: araddr=0x8000_0008, arlen=0, arsize=3, INCR, WAIT=0, SRAM word1=0x1122_3344_5566_7788. Expect mem_addr=1, rvalid at T+3, rdata=0x1122334455667788, rresp=00, rlast=1, arready=1 the cycle after the handshake.
- INCR burst arlen=3 from 0x8000_0000, rready tied high. Expect mem_addr 0,1,2,3, four beats 3 cycles apart, rlast only on beat 4, rid echoed (arid=5 gives rid=5).
- Backpressure: same burst with rready low 5 cycles on beat 2. Expect rdata/rlast/rid stable, no mem_en until the handshake, and beat 3 issued afterwards.
- FIXED burst arlen=2 at 0x8000_0010: expect mem_addr=2 on all three beats. WAIT=3: rvalid at T+6.
- Errors, each expecting no mem_en:
  - araddr=0x0 with arlen=1 returns two beats, rresp=11, rdata=0.
  - arburst=10 returns rresp=10.
  - arsize=4 with DATA_W=64 returns rresp=10.
  - araddr inside the window with an INCR end outside it returns rresp=11.
- Reset asserted during beat 2 of a 4-beat burst: rvalid=0 the next cycle, no further beats, and a new AR is accepted cleanly after reset.
